// File: rtl/fc_pkg.sv
// fc_pkg: shared widths and state encoding for the FC layer datapath
package fc_pkg;
  localparam int FC_DATA_WIDTH = 32;
  localparam int FC1_OUTPUTS = 84;
  localparam int FC1_INDEX_BITS = $clog2(FC1_OUTPUTS);
  typedef enum logic {ST_IDLE = 1'b0, ST_STREAM = 1'b1} fc_state_e;
endpackage

// File: rtl/fc1_outputs_streamer.sv
// fc1_outputs_streamer: captures the 84 FC1 activations at once and streams them oldest-first to FC2
module fc1_outputs_streamer
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = FC_DATA_WIDTH,
  parameter int NUMBER_OF_WORDS = FC1_OUTPUTS,
  parameter int INDEX_BITS = $clog2(NUMBER_OF_WORDS)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUMBER_OF_WORDS*DATA_WIDTH-1:0] load_data,
  input  logic                                  load_valid,
  output logic                                  load_ready,
  input  logic                                  flush,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [INDEX_BITS-1:0]                 out_index,
  output logic                                  out_last,
  output logic                                  done
);
  localparam logic [INDEX_BITS-1:0] LAST = INDEX_BITS'(NUMBER_OF_WORDS - 1);
  fc_state_e state_q, state_d;
  logic [INDEX_BITS-1:0] index_q, index_d;
  logic [DATA_WIDTH-1:0] buffer_q [NUMBER_OF_WORDS];
  logic done_q;
  logic at_last;
  logic xfer;
  assign at_last = index_q == LAST;
  assign xfer = out_valid && out_ready;
  // state, index and done-pulse registers; a flushed or reset stream never raises done
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      done_q <= xfer && at_last && !flush;
    end
  end
  // next state: flush is only honoured while streaming, the last transfer returns to idle
  always_comb begin
    state_d = state_q == ST_IDLE ? (load_valid ? ST_STREAM : ST_IDLE)
            : ((flush || (out_ready && at_last)) ? ST_IDLE : ST_STREAM);
    index_d = (state_q == ST_IDLE || flush) ? '0
            : out_ready ? (at_last ? '0 : index_q + 1'b1) : index_q;
  end
  // capture buffer loads the whole vector on an accepted load; never cleared
  always_ff @(posedge clk) begin
    if (load_valid && load_ready)
      for (int i = 0; i < NUMBER_OF_WORDS; i++)
        buffer_q[i] <= load_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
  // outputs decoded from state; data is zeroed whenever nothing is being offered
  always_comb begin
    load_ready = state_q == ST_IDLE;
    out_valid = state_q == ST_STREAM;
    out_data = out_valid ? buffer_q[index_q] : '0;
    out_index = index_q;
    out_last = out_valid && at_last;
    done = done_q;
  end
endmodule

// File: tb/tb_fc1_outputs_streamer.sv
// tb_fc1_outputs_streamer: scoreboard bench for the FC1 output streamer
module tb_fc1_outputs_streamer;
  localparam int W = 32;
  localparam int N = 84;
  localparam int IB = $clog2(N);
  typedef struct {
    logic [W-1:0] data;
    logic [IB-1:0] idx;
    logic last;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N*W-1:0] load_data = '0;
  logic load_valid = 1'b0;
  logic load_ready;
  logic flush = 1'b0;
  logic [W-1:0] out_data;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [IB-1:0] out_index;
  logic out_last;
  logic done;
  int n_vec = 0;
  int n_err = 0;
  exp_t exp_q[$];

  fc1_outputs_streamer dut (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_index(out_index), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] mk(input int base);
    logic [N*W-1:0] v;
    for (int k = 1; k <= N; k++) v[(k-1)*W +: W] = W'(base + k);
    return v;
  endfunction

  task automatic push(input int base);
    for (int k = 1; k <= N; k++) exp_q.push_back('{data: W'(base + k), idx: IB'(k - 1), last: k == N});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor: every offered word must match the queue head; a transfer pops it
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got %0h expected none", out_data);
      end else begin
        chk("out_data", out_data, exp_q[0].data);
        chk("out_index", 32'(out_index), 32'(exp_q[0].idx));
        chk("out_last", 32'(out_last), 32'(exp_q[0].last));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic load(input int base);
    load_valid = 1'b1;
    load_data = mk(base);
    push(base);
    cyc();
    load_valid = 1'b0;
    chk("latency_valid", 32'(out_valid), 1);
    chk("latency_index", 32'(out_index), 0);
    chk("busy_load_ready", 32'(load_ready), 0);
  endtask

  task automatic drain(input bit toggle, input bit arm_load, input int nxt_base);
    int c = 0;
    int x = 0;
    bit fin = 1'b0;
    while (!fin && c < 400) begin
      out_ready = toggle ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
      chk("done_early", 32'(done), 0);
      if (out_valid && out_ready) begin
        x++;
        fin = out_last;
      end
      if (fin && arm_load) begin
        load_valid = 1'b1;
        load_data = mk(nxt_base);
        push(nxt_base);
      end
      cyc();
      c++;
    end
    out_ready = 1'b0;
    chk("transfers", 32'(x), N);
    chk("done_pulse", 32'(done), 1);
    chk("load_ready_back", 32'(load_ready), 1);
    chk("valid_after", 32'(out_valid), 0);
    cyc();
    chk("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_load_ready", 32'(load_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", 32'(out_index), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_done", 32'(done), 0);
    // full-rate stream
    load(32'h100);
    drain(1'b0, 1'b0, 0);
    // stalled stream with 1,0,0,1 ready pattern
    load(32'h100);
    drain(1'b1, 1'b0, 0);
    // load held high during a stream: second vector taken only once idle
    load(32'h100);
    load_valid = 1'b1;
    load_data = mk(32'h200);
    push(32'h200);
    out_ready = 1'b1;
    begin
      int c = 0;
      while (!(out_last && out_ready) && c < 200) begin
        cyc();
        c++;
      end
      cyc();
      chk("held_done", 32'(done), 1);
      chk("held_not_streaming", 32'(out_valid), 0);
      cyc();
      load_valid = 1'b0;
      chk("held_captured_valid", 32'(out_valid), 1);
      chk("held_captured_index", 32'(out_index), 0);
    end
    drain(1'b0, 1'b0, 0);
    // flush after 10 transfers, with a transfer in the flush cycle
    load(32'h300);
    out_ready = 1'b1;
    repeat (10) cyc();
    chk("pre_flush_index", 32'(out_index), 10);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    out_ready = 1'b0;
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_load_ready", 32'(load_ready), 1);
    chk("flush_done", 32'(done), 0);
    chk("flush_data", out_data, 0);
    exp_q.delete();
    cyc();
    chk("flush_no_late_done", 32'(done), 0);
    // flush together with load in idle: load wins
    flush = 1'b1;
    load(32'h100);
    flush = 1'b0;
    drain(1'b0, 1'b0, 0);
    // reset mid-stream at index 40
    load(32'h200);
    out_ready = 1'b1;
    begin
      int c = 0;
      while (out_index != 40 && c < 200) begin
        cyc();
        c++;
      end
    end
    chk("reached_index40", 32'(out_index), 40);
    out_ready = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_q.delete();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_load_ready", 32'(load_ready), 1);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_index", 32'(out_index), 0);
    chk("mid_rst_last", 32'(out_last), 0);
    chk("mid_rst_done", 32'(done), 0);
    load(32'h100);
    drain(1'b0, 1'b0, 0);
    // load coinciding with the final transfer
    load(32'h300);
    drain(1'b0, 1'b1, 32'h100);
    load_valid = 1'b0;
    chk("coincide_valid", 32'(out_valid), 1);
    chk("coincide_index", 32'(out_index), 0);
    drain(1'b0, 1'b0, 0);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
